cmp_share_arbiter: RTL

- Shares one W-bit magnitude comparator (eq/lt/gt) among N requesters.
- Round-robin arbitration grants one request at a time. The block captures that requester's operands, runs the compare, and returns the result with a one-cycle acknowledge to the winner.
- Sits between the compare clients and the comparator datapath; the comparator logic lives inside the block.

---
 rtl/cmp_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin shared magnitude comparator: N requesters time-share one W-bit eq/lt/gt unit.
// Optional build macro COMPARE_SIGNED_EN selects two's-complement lt/gt (default: unsigned).
module cmp_share_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_bus,
  input  logic [N*W-1:0] b_bus,
  output logic [N-1:0]   ack,
  output logic           eq,
  output logic           lt,
  output logic           gt,
  output logic           busy
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [GW-1:0]  r_ptr;
  logic [GW-1:0]  r_gid;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [N-1:0]   r_ack;
  logic           r_eq;
  logic           r_lt;
  logic           r_gt;

  logic [GW-1:0]  w_win;
  logic           w_found;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic           w_eq;
  logic           w_lt;
  logic           w_gt;

  // Search starts just past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    logic [GW-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (v_idx == GW'(N - 1)) v_idx = '0;
      else                     v_idx = v_idx + GW'(1);
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == GW'(i)) begin
        w_sel_a = a_bus[i*W +: W];
        w_sel_b = b_bus[i*W +: W];
      end
    end
  end

  assign w_eq = (r_op_a == r_op_b);
`ifdef COMPARE_SIGNED_EN
  assign w_lt = ($signed(r_op_a) < $signed(r_op_b));
  assign w_gt = ($signed(r_op_a) > $signed(r_op_b));
`else
  assign w_lt = (r_op_a < r_op_b);
  assign w_gt = (r_op_a > r_op_b);
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_CMP;
      S_CMP:   w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= GW'(N - 1);
      r_gid  <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_ack  <= '0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
      r_gt   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_a <= w_sel_a;
            r_op_b <= w_sel_b;
            r_gid  <= w_win;
            r_ptr  <= w_win;
          end
        end
        S_CMP: begin
          r_eq  <= w_eq;
          r_lt  <= w_lt;
          r_gt  <= w_gt;
          r_ack <= N'(1) << r_gid;
        end
        default: r_ack <= '0;
      endcase
    end
  end

  assign ack  = r_ack;
  assign eq   = r_eq;
  assign lt   = r_lt;
  assign gt   = r_gt;
  assign busy = (r_state != S_IDLE);

endmodule
